// File: rtl/router_cmd_sequencer.sv
// router_cmd_sequencer: buffers (src, dst) transfer commands, waits for the
// link to qualify, then issues one registered request pulse per command to the
// router and holds off the next until a rising edge on router_done. Keeps
// transfer/cycle statistics and a sticky watchdog flag for hung transfers.
module router_cmd_sequencer #(
  parameter int DEPTH          = 16,
  parameter int STARTUP_WAIT   = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     user_clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [9:0]               cmd_src,
  input  logic [9:0]               cmd_dst,
  output logic                     router_start_req,
  output logic [9:0]               router_scr_addr,
  output logic [9:0]               router_dst_addr,
  input  logic                     router_done,
  output logic                     link_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [31:0]              stat_xfers,
  output logic [31:0]              stat_cycles,
  output logic                     timeout_err,
  input  logic                     stat_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);
  localparam logic [31:0]   SETTLE_LEN  = 32'(STARTUP_WAIT);
  localparam logic [31:0]   TIMEOUT_LEN = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0]   STAT_MAX    = 32'hFFFF_FFFF;
  // The phase counter stops one short of all-ones so "r_cnt + 1" never wraps.
  localparam logic [31:0]   CNT_SAT     = 32'hFFFF_FFFE;

  typedef enum logic [2:0] {
    S_INIT,
    S_SETTLE,
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [19:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;

  logic            r_done_q;
  logic [31:0]     r_cnt;
  logic            r_start_req;
  logic [9:0]      r_scr;
  logic [9:0]      r_dst;
  logic            r_link_ready;
  logic [31:0]     r_stat_xfers;
  logic [31:0]     r_stat_cycles;
  logic            r_timeout_err;

  logic            w_push;
  logic            w_pop;
  logic            w_not_full;
  logic [19:0]     w_head;
  logic            w_done_rise;
  logic            w_settle_end;
  logic            w_wd_expire;
  logic            w_busy;
  logic            w_xfer_done;
  logic            w_timeout_hit;

  assign w_not_full    = (r_level != FULL_LVL);
  assign w_push        = cmd_valid & w_not_full;
  assign w_pop         = (r_state == S_ISSUE);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_done_rise   = router_done & ~r_done_q;
  assign w_settle_end  = ((r_cnt + 32'd1) >= SETTLE_LEN);
  assign w_wd_expire   = (TIMEOUT_LEN != 32'd0) && ((r_cnt + 32'd1) >= TIMEOUT_LEN);
  assign w_busy        = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE) || (r_state == S_GAP);
  assign w_xfer_done   = (r_state == S_WAIT_DONE) && w_done_rise;
  assign w_timeout_hit = (r_state == S_WAIT_DONE) && !w_done_rise && w_wd_expire;

  // Command storage; payload only, so it carries no reset.
  always_ff @(posedge user_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_src, cmd_dst};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge user_clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Delayed copy of router_done for rising-edge detection.
  always_ff @(posedge user_clk) begin
    if (rst) r_done_q <= 1'b0;
    else     r_done_q <= router_done;
  end

  // State register.
  always_ff @(posedge user_clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:      if (router_done)             w_state_nxt = S_SETTLE;
      S_SETTLE:    if (w_settle_end)            w_state_nxt = S_IDLE;
      S_IDLE:      if (r_level != '0)           w_state_nxt = S_ISSUE;
      S_ISSUE:                                  w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (w_done_rise || w_wd_expire) w_state_nxt = S_GAP;
      S_GAP:                                    w_state_nxt = S_IDLE;
      default:                                  w_state_nxt = S_INIT;
    endcase
  end

  // Per-state cycle counter: restarts on every state change, so it times both
  // the settle window and the watchdog (cleared when ISSUE hands over to WAIT_DONE).
  always_ff @(posedge user_clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_SAT) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Registered request port: addresses are forced to zero outside the pulse.
  always_ff @(posedge user_clk) begin
    if (rst) begin
      r_start_req <= 1'b0;
      r_scr       <= '0;
      r_dst       <= '0;
    end else begin
      r_start_req <= w_pop;
      r_scr       <= w_pop ? w_head[19:10] : 10'd0;
      r_dst       <= w_pop ? w_head[9:0]   : 10'd0;
    end
  end

  // Link qualification flag, sticky until reset.
  always_ff @(posedge user_clk) begin
    if (rst) begin
      r_link_ready <= 1'b0;
    end else if ((r_state == S_SETTLE) && w_settle_end) begin
      r_link_ready <= 1'b1;
    end
  end

  // Statistics and watchdog flag; stat_clear takes priority over any update.
  always_ff @(posedge user_clk) begin
    if (rst || stat_clear) begin
      r_stat_xfers  <= '0;
      r_stat_cycles <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_xfer_done && (r_stat_xfers != STAT_MAX))  r_stat_xfers  <= r_stat_xfers + 32'd1;
      if (w_busy && (r_stat_cycles != STAT_MAX))      r_stat_cycles <= r_stat_cycles + 32'd1;
      if (w_timeout_hit)                              r_timeout_err <= 1'b1;
    end
  end

  assign cmd_ready        = w_not_full;
  assign router_start_req = r_start_req;
  assign router_scr_addr  = r_scr;
  assign router_dst_addr  = r_dst;
  assign link_ready       = r_link_ready;
  assign busy             = w_busy;
  assign fifo_level       = r_level;
  assign stat_xfers       = r_stat_xfers;
  assign stat_cycles      = r_stat_cycles;
  assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_router_cmd_sequencer.sv
// Directed bench for router_cmd_sequencer. The main instance (DEPTH=4) covers
// startup, single/back-to-back transfers, FIFO full, clear and reset; a second
// instance with TIMEOUT_CYCLES=20 covers the watchdog.
module tb_router_cmd_sequencer;

  localparam int DEPTH = 4;

  logic        user_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_src = '0;
  logic [9:0]  cmd_dst = '0;
  logic        router_start_req;
  logic [9:0]  router_scr_addr;
  logic [9:0]  router_dst_addr;
  logic        router_done = 1'b0;
  logic        link_ready;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [31:0] stat_xfers;
  logic [31:0] stat_cycles;
  logic        timeout_err;
  logic        stat_clear = 1'b0;

  logic        wd_cmd_valid = 1'b0;
  logic        wd_cmd_ready;
  logic [9:0]  wd_cmd_src = '0;
  logic [9:0]  wd_cmd_dst = '0;
  logic        wd_start_req;
  logic [9:0]  wd_scr;
  logic [9:0]  wd_dst;
  logic        wd_done = 1'b0;
  logic        wd_link_ready;
  logic        wd_busy;
  logic [4:0]  wd_fifo_level;
  logic [31:0] wd_stat_xfers;
  logic [31:0] wd_stat_cycles;
  logic        wd_timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_pulse = 0;
  int addr_bad = 0;
  int base;
  logic [9:0] q_src[$];
  logic [9:0] q_dst[$];
  logic [9:0] exp_src [5];
  logic [9:0] exp_dst [5];

  always #5 user_clk = ~user_clk;

  always @(posedge user_clk) cyc <= cyc + 1;

  // Record every request pulse and flag nonzero addresses outside a pulse.
  always @(negedge user_clk) begin
    if (router_start_req) begin
      n_pulse <= n_pulse + 1;
      q_src.push_back(router_scr_addr);
      q_dst.push_back(router_dst_addr);
    end else if ((router_scr_addr != 10'd0) || (router_dst_addr != 10'd0)) begin
      addr_bad <= addr_bad + 1;
    end
  end

  router_cmd_sequencer #(.DEPTH(DEPTH), .STARTUP_WAIT(10), .TIMEOUT_CYCLES(65535)) dut (
    .user_clk(user_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .router_start_req(router_start_req),
    .router_scr_addr(router_scr_addr), .router_dst_addr(router_dst_addr),
    .router_done(router_done), .link_ready(link_ready), .busy(busy),
    .fifo_level(fifo_level), .stat_xfers(stat_xfers), .stat_cycles(stat_cycles),
    .timeout_err(timeout_err), .stat_clear(stat_clear)
  );

  router_cmd_sequencer #(.DEPTH(16), .STARTUP_WAIT(10), .TIMEOUT_CYCLES(20)) dut_wd (
    .user_clk(user_clk), .rst(rst), .cmd_valid(wd_cmd_valid), .cmd_ready(wd_cmd_ready),
    .cmd_src(wd_cmd_src), .cmd_dst(wd_cmd_dst), .router_start_req(wd_start_req),
    .router_scr_addr(wd_scr), .router_dst_addr(wd_dst),
    .router_done(wd_done), .link_ready(wd_link_ready), .busy(wd_busy),
    .fifo_level(wd_fifo_level), .stat_xfers(wd_stat_xfers), .stat_cycles(wd_stat_cycles),
    .timeout_err(wd_timeout_err), .stat_clear(1'b0)
  );

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_main(input logic [9:0] s, input logic [9:0] d);
    cmd_valid = 1'b1;
    cmd_src   = s;
    cmd_dst   = d;
    tick();
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
  endtask

  task automatic wait_pulses(input int target, input string tag);
    for (int i = 0; i < 200 && n_pulse < target; i++) tick();
    chk(tag, n_pulse, target);
  endtask

  // Router model: answer each outstanding request with a done rising edge.
  task automatic serve(input int n, input int first);
    for (int k = 0; k < n; k++) begin
      wait_pulses(first + k, "pulse_arrives");
      repeat (3) tick();
      chk("hold_off", n_pulse, first + k);
      router_done = 1'b1;
      tick();
      router_done = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    exp_src[0] = 10'h000; exp_dst[0] = 10'h009;
    exp_src[1] = 10'h001; exp_dst[1] = 10'h005;
    exp_src[2] = 10'h002; exp_dst[2] = 10'h00F;
    exp_src[3] = 10'h003; exp_dst[3] = 10'h005;
    exp_src[4] = 10'h004; exp_dst[4] = 10'h009;

    // Reset state.
    repeat (3) tick();
    chk("rst_req", router_start_req, 0);
    chk("rst_link", link_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_xfers", stat_xfers, 0);
    chk("rst_to", timeout_err, 0);
    rst = 1'b0;
    tick();

    // Startup: queue two commands while the link is still down.
    push_main(10'h011, 10'h022);
    push_main(10'h033, 10'h044);
    chk("init_level", fifo_level, 2);
    chk("init_busy", busy, 0);

    // Watchdog instance: done held high forever, so no rising edge ever arrives.
    wd_done      = 1'b1;
    wd_cmd_valid = 1'b1; wd_cmd_src = 10'h0AA; wd_cmd_dst = 10'h0BB;
    tick();
    wd_cmd_src = 10'h0CC; wd_cmd_dst = 10'h0DD;
    tick();
    wd_cmd_valid = 1'b0;
    for (int i = 0; i < 40 && wd_start_req !== 1'b1; i++) tick();
    chk("wd_req1", wd_start_req, 1);
    chk("wd_src1", wd_scr, 10'h0AA);
    chk("wd_dst1", wd_dst, 10'h0BB);
    repeat (19) tick();
    chk("wd_to_before", wd_timeout_err, 0);
    chk("wd_busy", wd_busy, 1);
    tick();
    chk("wd_to_set", wd_timeout_err, 1);
    chk("wd_xfers", wd_stat_xfers, 0);
    chk("wd_cycles", wd_stat_cycles, 21);
    repeat (3) tick();
    chk("wd_req2", wd_start_req, 1);
    chk("wd_src2", wd_scr, 10'h0CC);
    chk("wd_dst2", wd_dst, 10'h0DD);
    chk("wd_to_sticky", wd_timeout_err, 1);
    chk("wd_level", wd_fifo_level, 0);
    chk("wd_ready", wd_cmd_ready, 1);
    chk("wd_link", wd_link_ready, 1);

    // Main link comes up at cycle 100.
    while (cyc < 100) tick();
    chk("still_init", busy, 0);
    router_done = 1'b1;
    repeat (10) tick();
    chk("settle_link0", link_ready, 0);
    tick();
    chk("settle_link1", link_ready, 1);
    chk("idle_noreq", router_start_req, 0);
    tick();
    chk("issue_busy", busy, 1);
    chk("issue_noreq", router_start_req, 0);
    tick();
    chk("start_cycle", cyc, 113);
    chk("start_req1", router_start_req, 1);
    chk("start_src1", router_scr_addr, 10'h011);
    chk("start_dst1", router_dst_addr, 10'h022);
    chk("start_level", fifo_level, 1);

    // A done level carried over from startup must not complete the transfer.
    repeat (5) tick();
    chk("level_no_done", stat_xfers, 0);
    chk("level_busy", busy, 1);
    router_done = 1'b0;
    tick();
    router_done = 1'b1;
    tick();
    chk("startup_x1", stat_xfers, 1);
    repeat (3) tick();
    chk("start_req2", router_start_req, 1);
    chk("start_src2", router_scr_addr, 10'h033);
    chk("start_dst2", router_dst_addr, 10'h044);
    router_done = 1'b0;
    tick();
    router_done = 1'b1;
    tick();
    chk("startup_x2", stat_xfers, 2);
    tick();
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    chk("clear_xfers", stat_xfers, 0);
    chk("clear_cycles", stat_cycles, 0);

    // Single transfer with a 50-cycle router latency.
    router_done = 1'b0;
    push_main(10'h005, 10'h00F);
    tick();
    chk("single_pre", router_start_req, 0);
    tick();
    chk("single_req", router_start_req, 1);
    chk("single_src", router_scr_addr, 10'h005);
    chk("single_dst", router_dst_addr, 10'h00F);
    repeat (50) tick();
    router_done = 1'b1;
    tick();
    tick();
    chk("single_xfers", stat_xfers, 1);
    chk("single_cycles", stat_cycles, 53);
    chk("single_idle", busy, 0);

    // Back-to-back ordering.
    stat_clear = 1'b1;
    tick();
    stat_clear  = 1'b0;
    router_done = 1'b0;
    base = n_pulse;
    for (int i = 0; i < 5; i++) push_main(exp_src[i], exp_dst[i]);
    serve(5, base + 1);
    repeat (2) tick();
    chk("b2b_xfers", stat_xfers, 5);
    for (int i = 0; i < 5; i++) begin
      chk("b2b_src", q_src[base + i], exp_src[i]);
      chk("b2b_dst", q_dst[base + i], exp_dst[i]);
    end

    // FIFO full: DEPTH+2 pushes with done held low.
    base = n_pulse;
    cmd_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      cmd_src = 10'(10'h100 + i);
      cmd_dst = 10'(10'h200 + i);
      tick();
    end
    cmd_valid = 1'b0;
    chk("full_level", fifo_level, DEPTH);
    chk("full_ready", cmd_ready, 0);
    serve(DEPTH + 1, base + 1);
    repeat (6) tick();
    chk("full_drained", fifo_level, 0);
    chk("full_count", n_pulse, base + DEPTH + 1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk("full_src", q_src[base + i], 10'(10'h100 + i));
      chk("full_dst", q_dst[base + i], 10'(10'h200 + i));
    end

    // stat_clear coincident with a done rise: the clear wins.
    base = n_pulse;
    push_main(10'h3FF, 10'h155);
    wait_pulses(base + 1, "clr_pulse");
    repeat (2) tick();
    router_done = 1'b1;
    stat_clear  = 1'b1;
    tick();
    stat_clear  = 1'b0;
    router_done = 1'b0;
    chk("clr_xfers", stat_xfers, 0);
    chk("clr_cycles", stat_cycles, 0);
    chk("clr_to", timeout_err, 0);
    tick();

    // Reset during WAIT_DONE with one command still queued.
    push_main(10'h001, 10'h002);
    push_main(10'h003, 10'h004);
    tick();
    tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_level", fifo_level, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", router_start_req, 0);
    chk("mid_rst_src", router_scr_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_link", link_ready, 0);
    chk("mid_rst_cycles", stat_cycles, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    rst = 1'b0;
    repeat (3) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_level", fifo_level, 0);
    chk("post_rst_link", link_ready, 0);

    chk("total_pulses", n_pulse, 15);
    chk("addr_idle_zero", addr_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
